multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Main control state machine for the multicycle MIPS datapath. It drives the ALUOp field consumed by the ALU control decoder, plus every datapath and memory strobe.
- Decodes the instruction opcode held in the IR. Sequences each instruction through fetch, decode, execute, memory and writeback.
- Stalls on a memory ready handshake and flags memory timeouts.

Parameters:
- WAIT_LIMIT, 255: consecutive MemReady-low cycles tolerated in a memory state before faulting (1..255).
- TIMER_WIDTH, 8: width of the wait counter; must hold WAIT_LIMIT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Opcode  in  6  IR[31:26]; sampled only in DECODE.
- MemReady  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  conditional PC load (branch).
- BranchNE  out  1  1 = PC loads on !Zero, 0 = PC loads on Zero.
- IorD  out  1  0 = PC address, 1 = ALUOut address.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  IR load.
- MemtoReg  out  1  register write data: 1 = MDR, 0 = ALUOut.
- RegDst  out  1  1 = rd, 0 = rt.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0 = PC, 1 = A.
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = SignExt, 11 = SignExt<<2.
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- ALUOp  out  3  111 = R-type, 100 = add, 101 = or, 001 = branch compare, 000 = idle.
- InstrDone  out  1  one-cycle pulse on the final cycle of each instruction.
- MemError  out  1  sticky memory-timeout flag.

Behaviour:
- Reset:
  - While reset = 1, all outputs are forced to 0, including ALUOp = 000 and MemError = 0.
  - The wait counter is cleared.
  - On the first edge after reset deasserts, the state is FETCH.
  - Reset mid-instruction aborts the instruction with no write strobe issued.
- Outputs are decoded from the current state. IRWrite, PCWrite in FETCH, and the memory-state exits are additionally gated by MemReady.
- FETCH:
  - Drives MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 100, PCSource = 00.
  - IRWrite and PCWrite are asserted only in the MemReady cycle; the state then goes to DECODE. Otherwise the FSM holds.
- DECODE:
  - Drives ALUSrcA = 0, ALUSrcB = 11, ALUOp = 100 (branch target into ALUOut).
  - Next state by Opcode:
    - 000000 -> R_EXEC
    - 001000 -> I_EXEC (add)
    - 001101 -> I_EXEC (or)
    - 100011 / 101011 -> MEM_ADDR
    - 000100 / 000101 -> BRANCH
    - 000010 -> JUMP
    - any other opcode -> FETCH, with InstrDone = 1 (treated as NOP).
  - The ADDI/ORI distinction is registered in DECODE and drives ALUOp in I_EXEC.
- R_EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 111 -> R_WB.
- R_WB: RegDst = 1, RegWrite = 1, MemtoReg = 0, InstrDone = 1 -> FETCH.
- I_EXEC: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 100 (ADDI) or 101 (ORI) -> I_WB.
- I_WB: RegDst = 0, RegWrite = 1, MemtoReg = 0, InstrDone = 1 -> FETCH.
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 100 -> MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: MemRead = 1, IorD = 1; exits to MEM_WB on MemReady.
- MEM_WB: RegDst = 0, RegWrite = 1, MemtoReg = 1, InstrDone = 1 -> FETCH.
- MEM_WRITE: MemWrite = 1, IorD = 1; exits to FETCH on MemReady, with InstrDone = 1 in that cycle.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 001, PCWriteCond = 1, PCSource = 01, BranchNE = (opcode was 000101), InstrDone = 1 -> FETCH.
- JUMP: PCWrite = 1, PCSource = 10, InstrDone = 1 -> FETCH.
- Latency with zero-wait memory, in cycles:
  - R-type 4, ADDI/ORI 4, LW 5, SW 4, BEQ/BNE 3, J 3, illegal opcode 2.
  - Each MemReady-low cycle adds one cycle.
- Wait timer:
  - Clears on entry to FETCH, MEM_READ or MEM_WRITE.
  - Increments on each cycle in those states with MemReady = 0.
  - When the count equals WAIT_LIMIT and MemReady = 0, the state goes to FAULT.
  - MemReady = 1 in the limit cycle wins: normal exit, no fault.
- FAULT: all strobes are 0, ALUOp = 000, MemError = 1. Only reset exits this state.
- No strobe may be asserted in two consecutive instructions' decode cycles. MemRead and MemWrite are never asserted together.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants (R_TYPE, ADDI, ORI, LW, SW, BEQ, BNE, J);
  - ALUOp codes (ALUOP_RTYPE = 111, ALUOP_ADD = 100, ALUOP_OR = 101, ALUOP_BRANCH = 001, ALUOP_IDLE = 000);
  - the state encoding (13 states, 4 bits).
- The ALUOp codes are the same values the ALU control decoder consumes.
- One sub-module, mem_wait_timer: inputs clear, count_en; output limit_hit; parameterised by WAIT_LIMIT and TIMER_WIDTH.

Test Plan:
- Reset held 3 cycles, then released with MemReady = 1 and Opcode = 000000 -> all outputs 0 during reset. Next cycles show FETCH (MemRead = 1, IRWrite = 1, ALUOp = 100), then DECODE, R_EXEC (ALUOp = 111), R_WB (RegWrite = 1, RegDst = 1, InstrDone = 1); 4 cycles total.
- LW (100011) with MemReady low for 3 cycles in MEM_READ -> MemRead = 1 and IorD = 1 held for 4 cycles. MEM_WB shows MemtoReg = 1, RegWrite = 1. Total 8 cycles.
- BNE (000101) -> BRANCH cycle shows ALUOp = 001, PCWriteCond = 1, BranchNE = 1, PCSource = 01. BEQ (000100) gives the same with BranchNE = 0. Each takes 3 cycles.
- ORI (001101), then ADDI (001000) -> I_EXEC shows ALUOp = 101, then 100, with ALUSrcB = 10. SW (101011) shows MemWrite = 1, no RegWrite, 4 cycles.
- MemReady held 0 in FETCH with WAIT_LIMIT = 4 -> FAULT entered after 4 wait cycles and MemError = 1 sticky. A second run with MemReady = 1 exactly on the 4th wait cycle gives a normal exit and no fault.
- Reset asserted in MEM_WRITE while MemReady = 0 -> next cycle MemWrite = 0 and the state is FETCH after release. Opcode 111111 -> 2-cycle NOP with InstrDone = 1 and no write strobes.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control FSM: opcode constants,
// ALUOp codes (same values the ALU control decoder consumes), state encoding
// and the packed control-strobe bundle.
package mips_ctrl_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned ALUOP_W  = 3;
    localparam int unsigned STATE_W  = 4;

    // Instruction opcodes (IR[31:26])
    localparam logic [OPCODE_W-1:0] R_TYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] ADDI   = 6'b001000;
    localparam logic [OPCODE_W-1:0] ORI    = 6'b001101;
    localparam logic [OPCODE_W-1:0] LW     = 6'b100011;
    localparam logic [OPCODE_W-1:0] SW     = 6'b101011;
    localparam logic [OPCODE_W-1:0] BEQ    = 6'b000100;
    localparam logic [OPCODE_W-1:0] BNE    = 6'b000101;
    localparam logic [OPCODE_W-1:0] J      = 6'b000010;

    // ALUOp codes
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE  = 3'b111;
    localparam logic [ALUOP_W-1:0] ALUOP_ADD    = 3'b100;
    localparam logic [ALUOP_W-1:0] ALUOP_OR     = 3'b101;
    localparam logic [ALUOP_W-1:0] ALUOP_BRANCH = 3'b001;
    localparam logic [ALUOP_W-1:0] ALUOP_IDLE   = 3'b000;

    // ALU operand / PC source selects
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_SEXT    = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH = 2'b11;
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_R_EXEC    = 4'd2,
        S_R_WB      = 4'd3,
        S_I_EXEC    = 4'd4,
        S_I_WB      = 4'd5,
        S_MEM_ADDR  = 4'd6,
        S_MEM_READ  = 4'd7,
        S_MEM_WB    = 4'd8,
        S_MEM_WRITE = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_FAULT     = 4'd12
    } state_t;

    // All datapath / memory strobes driven by the FSM
    typedef struct packed {
        logic               pc_write;
        logic               pc_write_cond;
        logic               branch_ne;
        logic               i_or_d;
        logic               mem_read;
        logic               mem_write;
        logic               ir_write;
        logic               mem_to_reg;
        logic               reg_dst;
        logic               reg_write;
        logic               alu_src_a;
        logic [1:0]         alu_src_b;
        logic [1:0]         pc_source;
        logic [ALUOP_W-1:0] alu_op;
        logic               instr_done;
        logic               mem_error;
    } ctrl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait timer: counts MemReady-low cycles within one memory state.
// Ports:
//   clk       - system clock, rising edge
//   clear     - synchronous clear (state entry or reset), wins over count_en
//   count_en  - increment this cycle
//   limit_hit - count equals WAIT_LIMIT
module mem_wait_timer #(
    parameter int unsigned WAIT_LIMIT  = 255,
    parameter int unsigned TIMER_WIDTH = 8
) (
    input  logic clk,
    input  logic clear,
    input  logic count_en,
    output logic limit_hit
);

    localparam logic [TIMER_WIDTH-1:0] LIMIT = TIMER_WIDTH'(WAIT_LIMIT);

    logic [TIMER_WIDTH-1:0] r_count;

    // Saturating counter; the FSM leaves the state once the limit is reached
    always_ff @(posedge clk) begin
        if (clear) begin
            r_count <= '0;
        end else if (count_en && (r_count != LIMIT)) begin
            r_count <= r_count + TIMER_WIDTH'(1);
        end
    end

    assign limit_hit = (r_count == LIMIT);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle MIPS datapath. Sequences each instruction
// through fetch/decode/execute/memory/writeback, stalls on MemReady and traps
// memory timeouts into a sticky FAULT state.
// Ports:
//   clk, reset     - clock and synchronous active-high reset
//   Opcode         - IR[31:26], sampled in DECODE only
//   MemReady       - memory completes the current access this cycle
//   PCWrite .. ALUOp - datapath / memory strobes decoded from current state
//   InstrDone      - pulse on the last cycle of each instruction
//   MemError       - sticky memory-timeout flag
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT  = 255,
    parameter int unsigned TIMER_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                MemReady,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                BranchNE,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSource,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                InstrDone,
    output logic                MemError
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl;
    logic   r_is_ori;
    logic   r_is_bne;
    logic   r_is_sw;
    logic   w_in_wait;
    logic   w_limit_hit;
    logic   w_timer_clear;
    logic   w_timer_en;

    // State register and opcode-derived flags latched in DECODE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_is_ori <= 1'b0;
            r_is_bne <= 1'b0;
            r_is_sw  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_is_ori <= (Opcode == ORI);
                r_is_bne <= (Opcode == BNE);
                r_is_sw  <= (Opcode == SW);
            end
        end
    end

    // Next-state and strobe decode
    always_comb begin
        w_next = r_state;
        w_ctrl = '0;
        unique case (r_state)
            S_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.alu_src_b = SRCB_FOUR;
                w_ctrl.alu_op    = ALUOP_ADD;
                w_ctrl.pc_source = PCSRC_ALU;
                if (MemReady) begin
                    w_ctrl.ir_write = 1'b1;
                    w_ctrl.pc_write = 1'b1;
                    w_next          = S_DECODE;
                end else if (w_limit_hit) begin
                    w_next = S_FAULT;
                end
            end
            S_DECODE: begin
                // Branch target computed speculatively into ALUOut
                w_ctrl.alu_src_b = SRCB_SEXT_SH;
                w_ctrl.alu_op    = ALUOP_ADD;
                case (Opcode)
                    R_TYPE:   w_next = S_R_EXEC;
                    ADDI, ORI: w_next = S_I_EXEC;
                    LW, SW:   w_next = S_MEM_ADDR;
                    BEQ, BNE: w_next = S_BRANCH;
                    J:        w_next = S_JUMP;
                    default: begin
                        // Unknown opcode retires as a NOP
                        w_ctrl.instr_done = 1'b1;
                        w_next            = S_FETCH;
                    end
                endcase
            end
            S_R_EXEC: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_B;
                w_ctrl.alu_op    = ALUOP_RTYPE;
                w_next           = S_R_WB;
            end
            S_R_WB: begin
                w_ctrl.reg_dst    = 1'b1;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.instr_done = 1'b1;
                w_next            = S_FETCH;
            end
            S_I_EXEC: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_SEXT;
                w_ctrl.alu_op    = r_is_ori ? ALUOP_OR : ALUOP_ADD;
                w_next           = S_I_WB;
            end
            S_I_WB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.instr_done = 1'b1;
                w_next            = S_FETCH;
            end
            S_MEM_ADDR: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_SEXT;
                w_ctrl.alu_op    = ALUOP_ADD;
                w_next           = r_is_sw ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.i_or_d   = 1'b1;
                if (MemReady) begin
                    w_next = S_MEM_WB;
                end else if (w_limit_hit) begin
                    w_next = S_FAULT;
                end
            end
            S_MEM_WB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.instr_done = 1'b1;
                w_next            = S_FETCH;
            end
            S_MEM_WRITE: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.i_or_d    = 1'b1;
                if (MemReady) begin
                    w_ctrl.instr_done = 1'b1;
                    w_next            = S_FETCH;
                end else if (w_limit_hit) begin
                    w_next = S_FAULT;
                end
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a     = 1'b1;
                w_ctrl.alu_src_b     = SRCB_B;
                w_ctrl.alu_op        = ALUOP_BRANCH;
                w_ctrl.pc_write_cond = 1'b1;
                w_ctrl.pc_source     = PCSRC_ALUOUT;
                w_ctrl.branch_ne     = r_is_bne;
                w_ctrl.instr_done    = 1'b1;
                w_next               = S_FETCH;
            end
            S_JUMP: begin
                w_ctrl.pc_write   = 1'b1;
                w_ctrl.pc_source  = PCSRC_JUMP;
                w_ctrl.instr_done = 1'b1;
                w_next            = S_FETCH;
            end
            S_FAULT: begin
                w_ctrl.mem_error = 1'b1;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
        // Reset overrides every strobe so an aborted instruction writes nothing
        if (reset) begin
            w_ctrl = '0;
        end
    end

    // Timer restarts whenever the FSM changes state, so entry to any wait state sees zero
    assign w_in_wait     = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                           (r_state == S_MEM_WRITE);
    assign w_timer_clear = reset || (w_next != r_state);
    assign w_timer_en    = w_in_wait && !MemReady;

    mem_wait_timer #(
        .WAIT_LIMIT  (WAIT_LIMIT),
        .TIMER_WIDTH (TIMER_WIDTH)
    ) u_wait_timer (
        .clk       (clk),
        .clear     (w_timer_clear),
        .count_en  (w_timer_en),
        .limit_hit (w_limit_hit)
    );

    assign PCWrite     = w_ctrl.pc_write;
    assign PCWriteCond = w_ctrl.pc_write_cond;
    assign BranchNE    = w_ctrl.branch_ne;
    assign IorD        = w_ctrl.i_or_d;
    assign MemRead     = w_ctrl.mem_read;
    assign MemWrite    = w_ctrl.mem_write;
    assign IRWrite     = w_ctrl.ir_write;
    assign MemtoReg    = w_ctrl.mem_to_reg;
    assign RegDst      = w_ctrl.reg_dst;
    assign RegWrite    = w_ctrl.reg_write;
    assign ALUSrcA     = w_ctrl.alu_src_a;
    assign ALUSrcB     = w_ctrl.alu_src_b;
    assign PCSource    = w_ctrl.pc_source;
    assign ALUOp       = w_ctrl.alu_op;
    assign InstrDone   = w_ctrl.instr_done;
    assign MemError    = w_ctrl.mem_error;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm (WAIT_LIMIT = 4).
// Each cycle's expected output vector is queued when the stimulus is driven
// and popped for comparison at the following falling edge.
module tb_multicycle_control_fsm;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       instr_done;
        logic       mem_error;
    } outs_t;

    typedef struct {
        logic       rst;
        logic       mr;
        logic [5:0] op;
        outs_t      exp;
    } step_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Opcode;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, InstrDone, MemError;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    outs_t      obs;

    int    n_tests = 0;
    int    n_fail  = 0;
    outs_t sb[$];
    step_t st[$];

    always #5 clk = ~clk;

    multicycle_control_fsm #(.WAIT_LIMIT(4), .TIMER_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUOp(ALUOp), .InstrDone(InstrDone), .MemError(MemError)
    );

    assign obs = {PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp,
                  InstrDone, MemError};

    // Expected output vectors per state
    function automatic outs_t e_fetch(input logic mr);
        outs_t e; e = '0;
        e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.alu_op = 3'b100;
        e.ir_write = mr; e.pc_write = mr;
        return e;
    endfunction
    function automatic outs_t e_decode(input logic done);
        outs_t e; e = '0;
        e.alu_src_b = 2'b11; e.alu_op = 3'b100; e.instr_done = done;
        return e;
    endfunction
    function automatic outs_t e_rexec();
        outs_t e; e = '0;
        e.alu_src_a = 1'b1; e.alu_op = 3'b111;
        return e;
    endfunction
    function automatic outs_t e_rwb();
        outs_t e; e = '0;
        e.reg_dst = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1;
        return e;
    endfunction
    function automatic outs_t e_iexec(input logic [2:0] aop);
        outs_t e; e = '0;
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = aop;
        return e;
    endfunction
    function automatic outs_t e_iwb();
        outs_t e; e = '0;
        e.reg_write = 1'b1; e.instr_done = 1'b1;
        return e;
    endfunction
    function automatic outs_t e_maddr();
        outs_t e; e = '0;
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 3'b100;
        return e;
    endfunction
    function automatic outs_t e_mread();
        outs_t e; e = '0;
        e.mem_read = 1'b1; e.i_or_d = 1'b1;
        return e;
    endfunction
    function automatic outs_t e_mwb();
        outs_t e; e = '0;
        e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.instr_done = 1'b1;
        return e;
    endfunction
    function automatic outs_t e_mwrite(input logic mr);
        outs_t e; e = '0;
        e.mem_write = 1'b1; e.i_or_d = 1'b1; e.instr_done = mr;
        return e;
    endfunction
    function automatic outs_t e_branch(input logic ne);
        outs_t e; e = '0;
        e.alu_src_a = 1'b1; e.alu_op = 3'b001; e.pc_write_cond = 1'b1;
        e.pc_source = 2'b01; e.branch_ne = ne; e.instr_done = 1'b1;
        return e;
    endfunction
    function automatic outs_t e_jump();
        outs_t e; e = '0;
        e.pc_write = 1'b1; e.pc_source = 2'b10; e.instr_done = 1'b1;
        return e;
    endfunction
    function automatic outs_t e_fault();
        outs_t e; e = '0;
        e.mem_error = 1'b1;
        return e;
    endfunction

    task automatic add(input logic rst, input logic mr, input logic [5:0] op, input outs_t e);
        step_t s;
        s.rst = rst; s.mr = mr; s.op = op; s.exp = e;
        st.push_back(s);
    endtask

    // Apply one step's inputs, queue its expectation, move to the sampling edge
    task automatic drive(input step_t s);
        reset    = s.rst;
        MemReady = s.mr;
        Opcode   = s.op;
        sb.push_back(s.exp);
        @(negedge clk);
    endtask

    task automatic test_reset();
        outs_t e;
        st.delete();
        for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 6'b000000, outs_t'('0));
        add(1'b0, 1'b1, 6'b000000, e_fetch(1'b1));
        add(1'b0, 1'b0, 6'b000000, e_decode(1'b0));
        add(1'b0, 1'b0, 6'b000000, e_rexec());
        add(1'b0, 1'b0, 6'b000000, e_rwb());
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_rtype[%0d] got %h expected %h", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_wait();
        outs_t e;
        st.delete();
        add(1'b0, 1'b1, 6'b100011, e_fetch(1'b1));
        add(1'b0, 1'b0, 6'b100011, e_decode(1'b0));
        add(1'b0, 1'b0, 6'b000000, e_maddr());
        for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 6'b000000, e_mread());
        add(1'b0, 1'b1, 6'b000000, e_mread());
        add(1'b0, 1'b0, 6'b000000, e_mwb());
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL lw_wait[%0d] got %h expected %h", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_jump();
        outs_t e;
        st.delete();
        add(1'b0, 1'b1, 6'b000000, e_fetch(1'b1));
        add(1'b0, 1'b0, 6'b000101, e_decode(1'b0));
        add(1'b0, 1'b0, 6'b000100, e_branch(1'b1));
        add(1'b0, 1'b1, 6'b000000, e_fetch(1'b1));
        add(1'b0, 1'b0, 6'b000100, e_decode(1'b0));
        add(1'b0, 1'b0, 6'b000101, e_branch(1'b0));
        add(1'b0, 1'b1, 6'b000000, e_fetch(1'b1));
        add(1'b0, 1'b0, 6'b000010, e_decode(1'b0));
        add(1'b0, 1'b0, 6'b000000, e_jump());
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL branch_jump[%0d] got %h expected %h", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_imm_sw();
        outs_t e;
        st.delete();
        add(1'b0, 1'b1, 6'b000000, e_fetch(1'b1));
        add(1'b0, 1'b0, 6'b001101, e_decode(1'b0));
        add(1'b0, 1'b0, 6'b001000, e_iexec(3'b101));
        add(1'b0, 1'b0, 6'b000000, e_iwb());
        add(1'b0, 1'b1, 6'b000000, e_fetch(1'b1));
        add(1'b0, 1'b0, 6'b001000, e_decode(1'b0));
        add(1'b0, 1'b0, 6'b001101, e_iexec(3'b100));
        add(1'b0, 1'b0, 6'b000000, e_iwb());
        add(1'b0, 1'b1, 6'b000000, e_fetch(1'b1));
        add(1'b0, 1'b0, 6'b101011, e_decode(1'b0));
        add(1'b0, 1'b0, 6'b100011, e_maddr());
        add(1'b0, 1'b1, 6'b000000, e_mwrite(1'b1));
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL imm_sw[%0d] got %h expected %h", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        outs_t e;
        st.delete();
        // Fetch timeout: four tolerated waits, fifth low cycle faults
        for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 6'b000000, e_fetch(1'b0));
        for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 6'b000000, e_fault());
        add(1'b1, 1'b1, 6'b000000, outs_t'('0));
        // Ready in the limit cycle exits normally
        for (int i = 0; i < 4; i++) add(1'b0, 1'b0, 6'b000000, e_fetch(1'b0));
        add(1'b0, 1'b1, 6'b000000, e_fetch(1'b1));
        add(1'b0, 1'b0, 6'b000010, e_decode(1'b0));
        add(1'b0, 1'b0, 6'b000000, e_jump());
        // Same boundary in MEM_WRITE
        add(1'b0, 1'b1, 6'b000000, e_fetch(1'b1));
        add(1'b0, 1'b0, 6'b101011, e_decode(1'b0));
        add(1'b0, 1'b0, 6'b000000, e_maddr());
        for (int i = 0; i < 4; i++) add(1'b0, 1'b0, 6'b000000, e_mwrite(1'b0));
        add(1'b0, 1'b1, 6'b000000, e_mwrite(1'b1));
        // MEM_READ timeout
        add(1'b0, 1'b1, 6'b000000, e_fetch(1'b1));
        add(1'b0, 1'b0, 6'b100011, e_decode(1'b0));
        add(1'b0, 1'b0, 6'b000000, e_maddr());
        for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 6'b000000, e_mread());
        add(1'b0, 1'b1, 6'b000000, e_fault());
        add(1'b1, 1'b0, 6'b000000, outs_t'('0));
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL timeout[%0d] got %h expected %h", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_abort_nop();
        outs_t e;
        st.delete();
        add(1'b0, 1'b1, 6'b000000, e_fetch(1'b1));
        add(1'b0, 1'b0, 6'b101011, e_decode(1'b0));
        add(1'b0, 1'b0, 6'b000000, e_maddr());
        add(1'b0, 1'b0, 6'b000000, e_mwrite(1'b0));
        add(1'b1, 1'b0, 6'b000000, outs_t'('0));
        add(1'b0, 1'b1, 6'b000000, e_fetch(1'b1));
        add(1'b0, 1'b0, 6'b111111, e_decode(1'b1));
        add(1'b0, 1'b1, 6'b000000, e_fetch(1'b1));
        add(1'b0, 1'b0, 6'b000000, e_decode(1'b0));
        add(1'b0, 1'b0, 6'b000000, e_rexec());
        add(1'b0, 1'b0, 6'b000000, e_rwb());
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL abort_nop[%0d] got %h expected %h", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset    = 1'b1;
        MemReady = 1'b1;
        Opcode   = 6'b000000;
        test_reset();
        test_lw_wait();
        test_branch_jump();
        test_imm_sw();
        test_timeout();
        test_abort_nop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
